// File: rtl/mul_pkg.sv
// Shared types and helpers for the RV32M multiply sequencer.
package mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } mul_state_t;

  // Accept edge to first out_valid cycle when the multiplier runs.
  localparam int MUL_LATENCY = 35;

  // Returns {sign1 (rs1 signed), sign0 (rs2 signed)}.
  function automatic logic [1:0] mul_signs(input mul_op_t op);
    logic [1:0] s;
    case (op)
      OP_MUL, OP_MULH: s = 2'b11;
      OP_MULHSU:       s = 2'b10;
      default:         s = 2'b00;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] mul_half(input mul_op_t op, input logic [63:0] prod);
    return (op == OP_MUL) ? prod[31:0] : prod[63:32];
  endfunction

endpackage

// File: rtl/mul_cache.sv
// Last-product cache for mul_ctrl: stores one completed product with its
// operands and sign bits and reports a hit for a matching new request.
module mul_cache
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fill_en,
  input  logic [31:0] fill_rs1,
  input  logic [31:0] fill_rs2,
  input  logic [1:0]  fill_signs,
  input  logic [63:0] fill_prod,
  input  logic [31:0] lk_rs1,
  input  logic [31:0] lk_rs2,
  input  mul_op_t     lk_op,
  output logic        hit,
  output logic [31:0] hit_data
);

  logic        vld_q, vld_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [1:0]  signs_q, signs_d;
  logic [63:0] prod_q, prod_d;
  logic        opnd_match;
  logic        sign_match;

  always_comb begin
    vld_d   = vld_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    signs_d = signs_q;
    prod_d  = prod_q;
    if (fill_en) begin
      vld_d   = 1'b1;
      rs1_d   = fill_rs1;
      rs2_d   = fill_rs2;
      signs_d = fill_signs;
      prod_d  = fill_prod;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q   <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      signs_q <= '0;
      prod_q  <= '0;
    end else begin
      vld_q   <= vld_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      signs_q <= signs_d;
      prod_q  <= prod_d;
    end
  end

  // The low product half does not depend on operand signedness.
  assign opnd_match = vld_q && (lk_rs1 == rs1_q) && (lk_rs2 == rs2_q);
  assign sign_match = (lk_op == OP_MUL) || (mul_signs(lk_op) == signs_q);
  assign hit        = opnd_match && sign_match;
  assign hit_data   = mul_half(lk_op, prod_q);

endmodule

// File: rtl/mul_ctrl.sv
// mul_ctrl: sequencing front-end between execute and the iterative multiplier.
// Define MUL_CACHE_EN to build the last-product cache (mul_cache).
//
// state | meaning
// IDLE  | waiting for a request
// RUN   | multiplier active on a live request
// DRAIN | multiplier active on a flushed request, result discarded
// HOLD  | result presented, waiting for out_ready
module mul_ctrl
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        busy,
  output logic        booth_go,
  output logic        booth_sign0,
  output logic        booth_sign1,
  output logic [31:0] booth_m,
  output logic [31:0] booth_r,
  input  logic        booth_done,
  input  logic [63:0] booth_result
);

  mul_state_t  state_q, state_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  mul_op_t     op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [4:0]  out_rd_q, out_rd_d;

  logic        accept;
  logic        hit;
  logic [31:0] hit_data;
  logic [1:0]  op_signs;
  mul_op_t     in_op_e;

  assign in_op_e  = mul_op_t'(in_op);
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign op_signs = mul_signs(op_q);

`ifdef MUL_CACHE_EN
  logic fill_en;

  // Only a live completion may refill; a drained product is never trusted.
  assign fill_en = (state_q == ST_RUN) && booth_done && !flush;

  mul_cache u_cache (
    .clk        (clk),
    .reset_n    (reset_n),
    .fill_en    (fill_en),
    .fill_rs1   (rs1_q),
    .fill_rs2   (rs2_q),
    .fill_signs (op_signs),
    .fill_prod  (booth_result),
    .lk_rs1     (in_rs1),
    .lk_rs2     (in_rs2),
    .lk_op      (in_op_e),
    .hit        (hit),
    .hit_data   (hit_data)
  );
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_d     = state_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    op_d        = op_q;
    rd_d        = rd_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_rd_d    = out_rd_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_RUN: begin
        // A flush landing on the done cycle has nothing left to drain.
        if (booth_done) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            state_d     = ST_HOLD;
            out_valid_d = 1'b1;
            out_data_d  = mul_half(op_q, booth_result);
            out_rd_d    = rd_q;
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (booth_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (flush || out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // accept is only possible from IDLE or a retiring HOLD with no flush.
    if (accept) begin
      rs1_d = in_rs1;
      rs2_d = in_rs2;
      op_d  = in_op_e;
      rd_d  = in_rd;
      if (hit) begin
        state_d     = ST_HOLD;
        out_valid_d = 1'b1;
        out_data_d  = hit_data;
        out_rd_d    = in_rd;
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      op_q        <= OP_MUL;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
    end else begin
      state_q     <= state_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_rd_q    <= out_rd_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_rd      = out_rd_q;
  assign busy        = (state_q != ST_IDLE);
  assign booth_go    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign booth_m     = rs1_q;
  assign booth_r     = rs2_q;
  assign booth_sign1 = op_signs[1];
  assign booth_sign0 = op_signs[0];

endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: behavioural multiplier, transaction-level reference
// model with per-cycle compare, directed literal cases and random traffic.
module tb_mul_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'd0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic [4:0]  in_rd = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        busy;
  logic        booth_go;
  logic        booth_sign0;
  logic        booth_sign1;
  logic [31:0] booth_m;
  logic [31:0] booth_r;
  logic        booth_done;
  logic [63:0] booth_result;

  int n_vec  = 0;
  int n_fail = 0;

`ifdef MUL_CACHE_EN
  localparam int HIT_LAT = 1;
  localparam int HIT_GO  = 0;
`else
  localparam int HIT_LAT = 35;
  localparam int HIT_GO  = 34;
`endif

  always #5 clk = ~clk;

  mul_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_rd        (in_rd),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_rd       (out_rd),
    .busy         (busy),
    .booth_go     (booth_go),
    .booth_sign0  (booth_sign0),
    .booth_sign1  (booth_sign1),
    .booth_m      (booth_m),
    .booth_r      (booth_r),
    .booth_done   (booth_done),
    .booth_result (booth_result)
  );

  function automatic logic [63:0] prod64(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] sg);
    logic [63:0] ea, eb;
    ea = sg[1] ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sg[0] ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  function automatic logic [1:0] signs_of(input logic [1:0] op);
    case (op)
      2'd0, 2'd1: return 2'b11;
      2'd2:       return 2'b10;
      default:    return 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] half_of(input logic [1:0] op, input logic [63:0] p);
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Multiplier stand-in: done on the 34th consecutive go cycle.
  logic [5:0] bcnt;
  always @(posedge clk) begin
    if (!reset_n)      bcnt <= 6'd0;
    else if (booth_go) bcnt <= (bcnt == 6'd33) ? 6'd0 : bcnt + 6'd1;
    else               bcnt <= 6'd0;
  end
  assign booth_done   = booth_go && (bcnt == 6'd33);
  assign booth_result = prod64(booth_m, booth_r, {booth_sign1, booth_sign0});

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a job finishes 34 edges after its accept edge.
  bit          m_job, m_live, m_hv, c_v;
  int          m_e, m_t;
  logic [31:0] m_rs1, m_rs2, m_hd, c_rs1, c_rs2;
  logic [1:0]  m_op, c_sg;
  logic [4:0]  m_rd, m_hr;
  logic [63:0] c_p;

  initial begin
    forever begin : model_step
      bit          rdy, acc, hit;
      logic [63:0] p;
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_job = 0; m_live = 0; m_hv = 0; c_v = 0; m_e = 0; m_t = 0;
      end else begin
        m_e++;
        rdy = (!m_job && !m_hv) || (m_hv && out_ready);
        acc = in_valid && rdy && !flush;
        if (m_hv && (flush || out_ready)) m_hv = 0;
        if (m_job && (m_e == m_t + 34)) begin
          m_job = 0;
          if (m_live && !flush) begin
            p     = prod64(m_rs1, m_rs2, signs_of(m_op));
            m_hv  = 1;
            m_hd  = half_of(m_op, p);
            m_hr  = m_rd;
            c_v   = 1;
            c_rs1 = m_rs1;
            c_rs2 = m_rs2;
            c_sg  = signs_of(m_op);
            c_p   = p;
          end
        end else if (m_job && flush) begin
          m_live = 0;
        end
        if (acc) begin
`ifdef MUL_CACHE_EN
          hit = c_v && (in_rs1 == c_rs1) && (in_rs2 == c_rs2) &&
                ((in_op == 2'd0) || (signs_of(in_op) == c_sg));
`else
          hit = 0;
`endif
          if (hit) begin
            m_hv = 1;
            m_hd = half_of(in_op, c_p);
            m_hr = in_rd;
          end else begin
            m_job  = 1;
            m_live = 1;
            m_t    = m_e;
            m_rs1  = in_rs1;
            m_rs2  = in_rs2;
            m_op   = in_op;
            m_rd   = in_rd;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("in_ready", 64'(in_ready), 64'((!m_job && !m_hv) || (m_hv && out_ready)));
        chk("busy", 64'(busy), 64'(m_job || m_hv));
        chk("booth_go", 64'(booth_go), 64'(m_job));
        chk("out_valid", 64'(out_valid), 64'(m_hv));
        if (m_hv) begin
          chk("out_data", 64'(out_data), 64'(m_hd));
          chk("out_rd", 64'(out_rd), 64'(m_hr));
        end
        if (m_job) begin
          chk("booth_m", 64'(booth_m), 64'(m_rs1));
          chk("booth_r", 64'(booth_r), 64'(m_rs2));
          chk("booth_signs", 64'({booth_sign1, booth_sign0}), 64'(signs_of(m_op)));
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input bit ordy, output int waits);
    bit got;
    got   = 0;
    waits = 0;
    @(posedge clk); #1;
    in_valid = 1; in_op = op; in_rs1 = a; in_rs2 = b; in_rd = rd;
    out_ready = ordy; flush = 0;
    while (!got && waits < 200) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
      waits++;
    end
    in_valid = 0;
    if (!got) begin
      n_vec++; n_fail++;
      $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic wait_out(output int lat, output int gocnt,
                          output logic [31:0] d, output logic [4:0] rd);
    lat = 0; gocnt = 0; d = '0; rd = '0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (booth_go) gocnt++;
      if (out_valid) begin
        lat = k; d = out_data; rd = out_rd;
        break;
      end
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_d, input int exp_lat, input int exp_go);
    int w, lat, g;
    logic [31:0] d;
    logic [4:0]  r;
    send(op, a, b, rd, 1'b1, w);
    wait_out(lat, g, d, r);
    chk({nm, "_data"}, 64'(d), 64'(exp_d));
    chk({nm, "_rd"}, 64'(r), 64'(rd));
    chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_go_cycles"}, 64'(g), 64'(exp_go));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd7;
      1: return 32'd9;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin : main
    int w, lat, g, goc, ov, last;
    logic [31:0] d;
    logic [4:0]  r;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_rd", 64'(out_rd), 64'd0);
    chk("rst_booth_go", 64'(booth_go), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_booth_m", 64'(booth_m), 64'd0);
    chk("rst_booth_r", 64'(booth_r), 64'd0);
    reset_n = 1;

    run_op("mul_m1x2",    2'd0, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFE, 35, 34);
    run_op("mulhu_m1x2",  2'd3, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'h0000_0001, 35, 34);
    run_op("mulhsu_m1x2", 2'd2, 32'hFFFF_FFFF, 32'd2, 5'd5, 32'hFFFF_FFFF, 35, 34);
    run_op("mulh_m1x2",   2'd1, 32'hFFFF_FFFF, 32'd2, 5'd6, 32'hFFFF_FFFF, 35, 34);
    run_op("mulh_min",    2'd1, 32'h8000_0000, 32'h8000_0000, 5'd7, 32'h4000_0000, 35, 34);
    run_op("mulhu_min",   2'd3, 32'h8000_0000, 32'h8000_0000, 5'd8, 32'h4000_0000, 35, 34);

    // Flush sampled on edge T+10 of a MULH.
    send(2'd1, 32'h1234_5678, 32'd9, 5'd9, 1'b1, w);
    goc = 0; ov = 0; last = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (booth_go) begin goc++; last = k; end
      if (out_valid) ov++;
      if (k == 10) begin #1; flush = 1; end
      else if (k == 11) begin #1; flush = 0; end
    end
    chk("flush_go_cycles", 64'(goc), 64'd34);
    chk("flush_go_last", 64'(last), 64'd34);
    chk("flush_no_output", 64'(ov), 64'd0);
    run_op("mul_after_flush", 2'd0, 32'd3, 32'd5, 5'd17, 32'h0000_000F, 35, 34);

    // Back-pressure in HOLD, then retire and accept on the same edge.
    send(2'd3, 32'h8000_0000, 32'd6, 5'h1B, 1'b0, w);
    wait_out(lat, g, d, r);
    chk("hold_latency", 64'(lat), 64'd35);
    chk("hold_data", 64'(d), 64'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid_stable", 64'(out_valid), 64'd1);
      chk("hold_data_stable", 64'(out_data), 64'd3);
      chk("hold_rd_stable", 64'(out_rd), 64'h1B);
    end
    send(2'd0, 32'd100, 32'd200, 5'd5, 1'b1, w);
    chk("hold_same_cycle_accept", 64'(w), 64'd1);
    wait_out(lat, g, d, r);
    chk("b2b_data", 64'(d), 64'h4E20);
    chk("b2b_rd", 64'(r), 64'd5);
    chk("b2b_latency", 64'(lat), 64'd35);

    run_op("cache_fill_mulh", 2'd1, 32'd7, 32'd9, 5'd1, 32'd0, 35, 34);
    run_op("cache_hit_mul",   2'd0, 32'd7, 32'd9, 5'd2, 32'h0000_003F, HIT_LAT, HIT_GO);

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_op     = 2'($urandom);
      in_rs1    = pick();
      in_rs2    = pick();
      in_rd     = 5'($urandom);
      flush     = ($urandom_range(0, 59) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (60) @(posedge clk);

    // Asynchronous reset in the middle of an operation.
    send(2'd0, 32'h11, 32'h22, 5'd4, 1'b1, w);
    repeat (5) @(posedge clk);
    #1; reset_n = 0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_go", 64'(booth_go), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1; reset_n = 1;
    run_op("mul_post_reset", 2'd0, 32'd7, 32'd9, 5'd6, 32'h0000_003F, 35, 34);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL global_timeout: got no completion expected finish before 1000000");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_ctrl.md
# mul_ctrl

Sequencing front-end for the RV32M multiply path. Sits between the execute stage and the `mul_booth` iterative multiplier. Accepts one MUL/MULH/MULHSU/MULHU request per valid/ready handshake, drives the multiplier's `go`, sign and operand inputs for the full iteration count, and selects the 32-bit half of the 64-bit product. Returns the half to writeback over a second valid/ready handshake, with flush support that never desynchronises the multiplier's internal step ring.

## Interface
- No parameters; widths fixed by RV32.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid & in_ready` and `flush` is low.
- `in_op`  in  2  funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `in_rs1`, `in_rs2`  in  32 each  source operands.
- `in_rd`  in  5  destination tag, returned unchanged.
- `flush`  in  1  kill any in-flight or held request.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  32  selected product half.
- `out_rd`  out  5  tag of the result.
- `busy`  out  1  state is not IDLE.
- `booth_go`, `booth_sign0`, `booth_sign1`  out  1 each  to multiplier.
- `booth_m`, `booth_r`  out  32 each  to multiplier.
- `booth_done`  in  1  from multiplier.
- `booth_result`  in  64  from multiplier.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: multiplier active on a live request.
  - DRAIN: multiplier active on a flushed request; result is discarded.
  - HOLD: `out_valid` high, waiting for `out_ready`.
- `in_ready = IDLE | (HOLD & out_ready)`. Back-to-back accept is allowed the same cycle the held result retires.
- On accept:
  - Latch rs1, rs2, op and rd.
  - Go to RUN.
- Operand mapping:
  - `booth_m = rs1`, `booth_sign1 = rs1 signed` (1 for MUL, MULH, MULHSU).
  - `booth_r = rs2`, `booth_sign0 = rs2 signed` (1 for MUL, MULH).
- `booth_go = RUN | DRAIN`.
  - Held high continuously from the first cycle until the cycle `booth_done` is sampled high inclusive.
  - Never dropped mid-operation, including on flush.
  - Deasserted the next cycle unless a new request was accepted.
- RUN & `booth_done`:
  - Register `out_data` = `booth_result[31:0]` for MUL, else `booth_result[63:32]`.
  - Register `out_rd`; go to HOLD.
- HOLD & `out_ready`: go to IDLE, or to RUN if a new request is accepted in the same cycle.
- Flush handling (flush has priority over every other event):
  - IDLE: no effect; a simultaneous `in_valid` is not accepted.
  - RUN: go to DRAIN. The product still completes, `booth_done` then moves to IDLE, and nothing is output.
  - HOLD: drop `out_valid` next cycle, go to IDLE, and suppress any same-cycle accept.
  - DRAIN: stays DRAIN.
- Reset values: state IDLE, `out_valid` 0, `out_data` 0, `out_rd` 0, `booth_go` 0, latched operands 0, `in_ready` 1.
- Reset mid-operation: state is cleared immediately.
  - The multiplier's ring resets synchronously on the same `reset_n`.
  - System rule: `reset_n` is held low across at least one `clk` edge.

## Timing
- Accept edge at T:
  - `booth_go` high on cycles T+1 .. T+34.
  - `booth_done` on T+34.
  - `out_valid` from T+35.
- Latency from accept to result: 35 cycles.
- Throughput: one result per 35 cycles with `out_ready` tied high.
- `out_data` and `out_rd` are stable while `out_valid & ~out_ready`.
- All outputs are registered except `in_ready` and the `booth_*` operand and sign lines. Those are driven from latched registers and are stable for the whole RUN or DRAIN period.

## Configuration
- `MUL_CACHE_EN`:
  - Defined: keep the last completed 64-bit product with its rs1, rs2, `sign1` and `sign0`.
  - Hit rule:
    - A MUL hits if rs1 and rs2 match (low half is sign-independent).
    - MULH/MULHSU/MULHU hit only if rs1, rs2 and both sign bits match.
  - On a hit: go straight to HOLD, `out_valid` at T+1, `booth_go` never asserted.
  - The cache fills only on RUN completion, never on DRAIN. It is invalidated on reset.
  - Undefined: every request runs the multiplier; no cache storage.

## Structure
- Package `mul_pkg` holds:
  - `mul_op_t` (MUL/MULH/MULHSU/MULHU encodings).
  - `mul_state_t` (IDLE/RUN/DRAIN/HOLD).
  - Constant `MUL_LATENCY = 35`.
  - Function `mul_signs(op)` returning {`sign1`, `sign0`}.
- One sub-module, `mul_cache`, instantiated only under `MUL_CACHE_EN`. It contains the product/tag registers and the hit compare.
- `mul_booth` is instantiated by the parent execute unit, not inside `mul_ctrl`.

## Test plan
- MUL rs1=0xFFFFFFFF, rs2=0x00000002 -> `out_data` 0xFFFFFFFE, `out_valid` exactly 35 cycles after accept, `booth_go` high 34 cycles.
- MULH / MULHSU / MULHU with rs1=0xFFFFFFFF, rs2=0x00000002 -> 0xFFFFFFFF / 0xFFFFFFFF / 0x00000001.
- MULH and MULHU with rs1=rs2=0x80000000 -> 0x40000000 both.
- Flush at cycle T+10 of a MULH:
  - `booth_go` stays high through T+34; no `out_valid`.
  - A following MUL 3×5 returns 0x0000000F at correct latency.
- `out_ready` low 5 cycles in HOLD: data and rd stable. Then `out_ready` high with a new `in_valid`: accept the same cycle, and the next result is correct.
- With `MUL_CACHE_EN`: MULH 7×9 then MUL 7×9 -> second result 0x0000003F with `out_valid` 1 cycle after accept and no `booth_go`.
